// File: rtl/cu_cmd_issuer.sv
// Command issuer for the cu control-unit decoder: buffers 2-bit channel requests
// and serialises each one into a select-setup / mode-strobe / recovery frame.
module cu_cmd_issuer #(
   parameter int DEPTH = 4,
   parameter int HOLD  = 2,
   parameter int GAP   = 1,
   parameter int CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req_valid,
   input  logic [1:0]       req_chan,
   output logic             req_ready,
   output logic [3:0]       cmd_sel,
   output logic             cmd_m4,
   output logic             cmd_m5,
   output logic             cmd_m13,
   output logic             cmd_busy,
   output logic [CNT_W-1:0] issued_count,
   output logic             overflow
);

   localparam int PW   = $clog2(DEPTH);
   localparam int CW   = PW + 1;
   localparam int TMAX = (HOLD > GAP) ? HOLD : GAP;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, RECOVER} state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [1:0]       mem_q [DEPTH];
   logic [1:0]       chan_q, chan_d;
   logic [TW-1:0]    tmr_q, tmr_d;
   logic [CNT_W-1:0] issued_q, issued_d;
   logic             ready_q, ready_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic [3:0]       sel_q, sel_d;
   logic             m5_q, m5_d;
   logic             m13_q, m13_d;
   logic             push, pop, empty, frame_done;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      empty      = (count_q == '0);
      push       = req_valid & ready_q;
      pop        = 1'b0;
      frame_done = 1'b0;
      state_d    = state_q;
      chan_d     = chan_q;
      tmr_d      = tmr_q;
      issued_d   = issued_q;

      case (state_q)
         IDLE:    frame_done = 1'b1;
         SETUP: begin
            state_d = STROBE;
            tmr_d   = TW'(HOLD - 1);
         end
         STROBE: begin
            if (tmr_q != '0) begin
               tmr_d = tmr_q - TW'(1);
            end else begin
               issued_d = issued_q + CNT_W'(1);
               if (GAP > 0) begin
                  state_d = RECOVER;
                  tmr_d   = TW'(GAP - 1);
               end else begin
                  frame_done = 1'b1;
               end
            end
         end
         RECOVER: begin
            if (tmr_q != '0) tmr_d = tmr_q - TW'(1);
            else             frame_done = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      // Frame boundary: start the next queued request back-to-back, or fall idle.
      if (frame_done) begin
         if (!empty) begin
            pop     = 1'b1;
            chan_d  = mem_q[rd_ptr_q];
            state_d = SETUP;
         end else begin
            state_d = IDLE;
         end
      end

      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      // A pop at the same edge frees space only for the following cycle.
      ready_d = (count_d != CW'(DEPTH));
      ovf_d   = ovf_q | (req_valid & ~ready_q);
      busy_d  = (state_q != IDLE) | ~empty;

      sel_d = 4'b1100;
      m5_d  = 1'b0;
      m13_d = 1'b1;
      if (state_q != IDLE) begin
         sel_d = {2'b00, chan_q};
         m13_d = 1'b0;
         m5_d  = (state_q == STROBE);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only; the FIFO storage is
   // deliberately left out of reset since its contents are never read while empty.
   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q] <= req_chan;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         chan_q   <= '0;
         tmr_q    <= '0;
         issued_q <= '0;
         ready_q  <= 1'b1;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         sel_q    <= 4'b1100;
         m5_q     <= 1'b0;
         m13_q    <= 1'b1;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         chan_q   <= chan_d;
         tmr_q    <= tmr_d;
         issued_q <= issued_d;
         ready_q  <= ready_d;
         ovf_q    <= ovf_d;
         busy_q   <= busy_d;
         sel_q    <= sel_d;
         m5_q     <= m5_d;
         m13_q    <= m13_d;
      end
   end

   assign req_ready    = ready_q;
   assign cmd_sel      = sel_q;
   assign cmd_m4       = 1'b0;
   assign cmd_m5       = m5_q;
   assign cmd_m13      = m13_q;
   assign cmd_busy     = busy_q;
   assign issued_count = issued_q;
   assign overflow     = ovf_q;

endmodule

// File: tb/tb_cu_cmd_issuer.sv
// Self-checking bench for cu_cmd_issuer: directed table, corner sequences and
// randomized traffic against a frame-position reference model.
module tb_cu_cmd_issuer;

   localparam int DEPTH = 4;
   localparam int HOLD  = 2;
   localparam int GAP   = 1;
   localparam int FLEN  = 1 + HOLD + GAP;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       req_valid = 1'b0;
   logic [1:0] req_chan = 2'd0;

   logic       req_ready, cmd_m4, cmd_m5, cmd_m13, cmd_busy, overflow;
   logic [3:0] cmd_sel;
   logic [7:0] issued_count;

   logic       b_ready, b_m4, b_m5, b_m13, b_busy, b_ovf;
   logic [3:0] b_sel;
   logic [1:0] b_count;

   cu_cmd_issuer #(.DEPTH(DEPTH), .HOLD(HOLD), .GAP(GAP), .CNT_W(8)) u_dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_chan(req_chan),
      .req_ready(req_ready), .cmd_sel(cmd_sel), .cmd_m4(cmd_m4), .cmd_m5(cmd_m5),
      .cmd_m13(cmd_m13), .cmd_busy(cmd_busy), .issued_count(issued_count),
      .overflow(overflow)
   );

   cu_cmd_issuer #(.DEPTH(DEPTH), .HOLD(HOLD), .GAP(GAP), .CNT_W(2)) u_dut_b (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_chan(req_chan),
      .req_ready(b_ready), .cmd_sel(b_sel), .cmd_m4(b_m4), .cmd_m5(b_m5),
      .cmd_m13(b_m13), .cmd_busy(b_busy), .issued_count(b_count),
      .overflow(b_ovf)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: queue of accepted channels plus position within the running frame.
   int   q[$];
   bit   m_active;
   int   m_p;
   int   m_ch;
   int   m_cnt;
   bit   m_ovf;
   bit   m_ready;
   logic [3:0] e_sel;
   bit   e_m5, e_m13, e_busy;

   bit         prev_m5;
   logic [3:0] prev_sel;
   logic [1:0] prev_cb;
   int         frames[$];
   int         cseq[$];

   typedef struct {
      bit         v;
      logic [1:0] ch;
      logic [3:0] sel;
      bit         m5;
      bit         m13;
      bit         busy;
      int         cnt;
   } vec_t;

   vec_t tbl [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_active = 1'b0;
      m_p      = 0;
      m_ch     = 0;
      m_cnt    = 0;
      m_ovf    = 1'b0;
      m_ready  = 1'b1;
      prev_m5  = 1'b0;
      prev_sel = 4'b1100;
      prev_cb  = 2'd0;
   endtask

   // Outputs after an edge reflect the frame position held during the preceding cycle.
   task automatic model_step(input bit v, input int ch);
      bit ready_before;
      ready_before = m_ready;
      if (!m_active) begin
         e_sel = 4'b1100; e_m5 = 1'b0; e_m13 = 1'b1;
      end else begin
         e_sel = {2'b00, m_ch[1:0]}; e_m13 = 1'b0;
         e_m5  = (m_p >= 1) && (m_p <= HOLD);
      end
      e_busy = m_active || (q.size() > 0);
      if (m_active && m_p == HOLD) m_cnt++;
      if (m_active && m_p < FLEN - 1) begin
         m_p++;
      end else if (q.size() > 0) begin
         m_ch = q.pop_front(); m_active = 1'b1; m_p = 0;
      end else begin
         m_active = 1'b0;
      end
      if (v) begin
         if (ready_before) q.push_back(ch);
         else              m_ovf = 1'b1;
      end
      m_ready = (q.size() < DEPTH);
   endtask

   task automatic compare_all();
      check("sel", cmd_sel, e_sel);
      check("m4", cmd_m4, 1'b0);
      check("m5", cmd_m5, e_m5);
      check("m13", cmd_m13, e_m13);
      check("ready", req_ready, m_ready);
      check("busy", cmd_busy, e_busy);
      check("count", issued_count, 32'(m_cnt % 256));
      check("overflow", overflow, m_ovf);
      check("b_count", b_count, 32'(m_cnt % 4));
      check("b_sel", b_sel, e_sel);
      if (cmd_m5) begin
         check("inv_m5_sel", cmd_sel[3:2], 2'b00);
         check("inv_m5_m13", cmd_m13, 1'b0);
      end
      if (prev_m5 && cmd_m5) check("inv_sel_stable", cmd_sel, prev_sel);
      if (cmd_m5 && !prev_m5) frames.push_back(int'(cmd_sel[1:0]));
      if (b_count != prev_cb) cseq.push_back(int'(b_count));
      prev_m5  = cmd_m5;
      prev_sel = cmd_sel;
      prev_cb  = b_count;
   endtask

   // Drive inputs for one edge, advance the model, compare #1 after the edge.
   task automatic cycle(input bit v, input logic [1:0] ch);
      req_valid = v;
      req_chan  = ch;
      @(posedge clock);
      model_step(v, int'(ch));
      #1;
      compare_all();
   endtask

   task automatic drain();
      for (int i = 0; i < 200; i++) begin
         cycle(1'b0, 2'd0);
         if (!cmd_busy) break;
      end
      check("drain_done", cmd_busy, 1'b0);
   endtask

   task automatic apply_reset();
      req_valid = 1'b0;
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      tbl[0] = '{1'b1, 2'd2, 4'b1100, 1'b0, 1'b1, 1'b0, 0};
      tbl[1] = '{1'b0, 2'd0, 4'b1100, 1'b0, 1'b1, 1'b1, 0};
      tbl[2] = '{1'b0, 2'd0, 4'b0010, 1'b0, 1'b0, 1'b1, 0};
      tbl[3] = '{1'b0, 2'd0, 4'b0010, 1'b1, 1'b0, 1'b1, 0};
      tbl[4] = '{1'b0, 2'd0, 4'b0010, 1'b1, 1'b0, 1'b1, 1};
      tbl[5] = '{1'b0, 2'd0, 4'b0010, 1'b0, 1'b0, 1'b1, 1};
      tbl[6] = '{1'b0, 2'd0, 4'b1100, 1'b0, 1'b1, 1'b0, 1};
      tbl[7] = '{1'b0, 2'd0, 4'b1100, 1'b0, 1'b1, 1'b0, 1};

      // Reset then idle.
      apply_reset();
      repeat (5) cycle(1'b0, 2'd0);
      check("rst_sel", cmd_sel, 4'b1100);
      check("rst_m13", cmd_m13, 1'b1);
      check("rst_m5", cmd_m5, 1'b0);
      check("rst_ready", req_ready, 1'b1);
      check("rst_count", issued_count, 8'd0);
      check("rst_ovf", overflow, 1'b0);
      check("rst_busy", cmd_busy, 1'b0);

      // Single frame on channel 2, cycle by cycle.
      for (int i = 0; i < 8; i++) begin
         cycle(tbl[i].v, tbl[i].ch);
         check($sformatf("tbl%0d_sel", i), cmd_sel, tbl[i].sel);
         check($sformatf("tbl%0d_m5", i), cmd_m5, tbl[i].m5);
         check($sformatf("tbl%0d_m13", i), cmd_m13, tbl[i].m13);
         check($sformatf("tbl%0d_busy", i), cmd_busy, tbl[i].busy);
         check($sformatf("tbl%0d_cnt", i), issued_count, 32'(tbl[i].cnt));
      end

      // Four back-to-back requests.
      frames.delete();
      for (int i = 0; i < 4; i++) cycle(1'b1, 2'(i));
      drain();
      check("b2b_frames", frames.size(), 4);
      for (int i = 0; i < 4 && i < frames.size(); i++)
         check($sformatf("b2b_frame%0d", i), frames[i], i);
      check("b2b_count", issued_count, 8'd5);

      // Six requests into a four-deep FIFO while the first frame runs.
      frames.delete();
      for (int i = 0; i < 6; i++) cycle(1'b1, 2'(i % 4));
      drain();
      check("ovf_set", overflow, 1'b1);
      check("ovf_frames", frames.size(), 5);
      check("ovf_count", issued_count, 8'd10);
      repeat (5) cycle(1'b0, 2'd0);
      check("ovf_sticky", overflow, 1'b1);

      // Reset mid-strobe of channel 3 with two requests queued.
      cycle(1'b1, 2'd3);
      cycle(1'b1, 2'd0);
      cycle(1'b1, 2'd1);
      for (int i = 0; i < 20; i++) begin
         if (cmd_m5) break;
         cycle(1'b0, 2'd0);
      end
      check("mid_strobe_m5", cmd_m5, 1'b1);
      check("mid_strobe_sel", cmd_sel, 4'b0011);
      #1;
      reset = 1'b1;
      #1;
      check("arst_sel", cmd_sel, 4'b1100);
      check("arst_m5", cmd_m5, 1'b0);
      check("arst_m13", cmd_m13, 1'b1);
      check("arst_ready", req_ready, 1'b1);
      check("arst_busy", cmd_busy, 1'b0);
      check("arst_count", issued_count, 8'd0);
      check("arst_ovf", overflow, 1'b0);
      @(posedge clock);
      @(posedge clock);
      #1;
      reset = 1'b0;
      model_reset();
      frames.delete();
      repeat (20) cycle(1'b0, 2'd0);
      check("post_rst_frames", frames.size(), 0);
      check("post_rst_count", issued_count, 8'd0);

      // Narrow counter wraps: 1,2,3,0,1.
      cseq.delete();
      for (int i = 0; i < 5; i++) cycle(1'b1, 2'(i % 4));
      drain();
      check("wrap_len", cseq.size(), 5);
      if (cseq.size() == 5) begin
         check("wrap0", cseq[0], 1);
         check("wrap1", cseq[1], 2);
         check("wrap2", cseq[2], 3);
         check("wrap3", cseq[3], 0);
         check("wrap4", cseq[4], 1);
      end

      // Randomized traffic: a heavy phase to exercise full/overflow, then a light phase.
      for (int i = 0; i < 400; i++) begin
         bit v;
         v = (i < 200) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
         cycle(v, 2'($urandom_range(0, 3)));
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cu_cmd_issuer.md
Name: cu_cmd_issuer

Overview:
- Command-side counterpart to the cu control-unit decoder.
- Accepts 2-bit channel requests through a valid/ready handshake and buffers them in a small FIFO.
- Serialises each request into a timed command frame on the decoder's select/mode lines: select setup, mode-strobe window, recovery gap.
- Provides busy status, a wrapping issued-frame counter and a sticky overflow flag.

Parameters:
DEPTH, 4, request FIFO entries (power of two, >=2)
HOLD, 2, cycles cmd_m5 is held high per frame (>=1)
GAP, 1, recovery cycles after strobe before next frame (>=0)
CNT_W, 8, width of issued_count

Ports:
clock  in  1  single clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
req_valid  in  1  request offered
req_chan  in  2  channel id to issue (0..3)
req_ready  out  1  FIFO not full
cmd_sel  out  4  decoder select lines: [1:0]=channel, [3:2]=00 during a frame
cmd_m4  out  1  decoder mode line, always 0 while a frame is active
cmd_m5  out  1  decoder strobe-enable line
cmd_m13  out  1  decoder inhibit line
cmd_busy  out  1  frame in progress or FIFO non-empty
issued_count  out  CNT_W  completed frames, wraps modulo 2^CNT_W
overflow  out  1  sticky: req_valid seen while FIFO full

Behaviour:
- Reset (async assert, any state, mid-frame included):
  - FIFO emptied; state=IDLE; issued_count=0; overflow=0.
  - cmd_sel=4'b1100, cmd_m4=0, cmd_m5=0, cmd_m13=1.
  - req_ready=1, cmd_busy=0.
  - An aborted frame is not counted and is not retried.
- Handshake:
  - A push occurs on a rising edge with req_valid&req_ready.
  - req_ready = !full, registered, derived from the FIFO count.
  - req_valid while full: request dropped, overflow set to 1 (cleared only by reset).
- Simultaneous push and pop when full:
  - The pop does not free space in the same cycle; req_ready stays 0.
  - The push is dropped and sets overflow.
- Simultaneous push and pop when neither full nor empty: count unchanged, both take effect.
- FIFO ordering: strict first-in first-out; pointers wrap modulo DEPTH.
- FSM states are IDLE, SETUP, STROBE, RECOVER. All outputs are registered.
- IDLE:
  - Outputs: cmd_sel=4'b1100, cmd_m5=0, cmd_m13=1.
  - If the FIFO is non-empty: pop the head, latch the channel, go to SETUP.
  - Pop-to-SETUP latency is 1 cycle. A request pushed into an empty FIFO at edge N reaches SETUP outputs at edge N+2.
- SETUP (1 cycle):
  - Outputs: cmd_sel={2'b00,chan}, cmd_m13=0, cmd_m5=0.
  - Next state: STROBE.
- STROBE (HOLD cycles):
  - Outputs: cmd_sel held, cmd_m13=0, cmd_m5=1.
  - Hold counter is loaded with HOLD-1 on entry and counts down.
  - At 0: go to RECOVER; issued_count increments on this exit transition.
- RECOVER (GAP cycles):
  - Outputs: cmd_m5=0, cmd_sel held, cmd_m13=0.
  - At the end:
    - FIFO non-empty: pop and go directly to SETUP with the new channel (back-to-back, no IDLE cycle).
    - FIFO empty: go to IDLE.
  - GAP=0: RECOVER is skipped. STROBE exits straight to SETUP or IDLE, and cmd_m5 still drops for the 1 SETUP cycle.
- Invariants:
  - cmd_m4 is always 0.
  - cmd_m5=1 only when cmd_sel[3:2]=00 and cmd_m13=0.
  - cmd_sel never changes while cmd_m5=1.
- cmd_busy = (state!=IDLE) | !empty.
- issued_count wraps from 2^CNT_W-1 to 0 with no flag.

Test Plan:
- Reset then idle 5 cycles -> cmd_sel=1100, cmd_m13=1, cmd_m5=0, req_ready=1, issued_count=0, overflow=0, cmd_busy=0.
- Single push chan=2 at edge 0 (HOLD=2, GAP=1) -> SETUP at edge 2 with cmd_sel=0010, m5=0; m5=1 for edges 3-4; RECOVER at edge 5; IDLE at edge 6 with cmd_sel=1100; issued_count=1.
- Push 0,1,2,3 on consecutive cycles -> four frames in order with cmd_sel low bits 0,1,2,3; no IDLE between frames; issued_count=4; cmd_busy falls only after the last RECOVER.
- Push 6 requests back-to-back while the first frame runs (DEPTH=4) -> req_ready drops when full; 6th request dropped; overflow=1 and stays 1; exactly 5 frames issued.
- Assert reset mid-STROBE of chan=3 with 2 queued requests -> outputs return to reset values immediately; issued_count=0; no frames follow after reset release.
- CNT_W=2: issue 5 frames -> issued_count sequence 1,2,3,0,1.
